// File: rtl/cnu_pkg.sv
// Shared definitions for the serial check-node min-finder.
// Holds default widths, the controller state encoding and the padding magnitude.
package cnu_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_IDX_W   = 8;
    localparam int unsigned DEF_MAX_DEG = 32;
    localparam int unsigned DEF_CNT_W   = 6;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Magnitude used to pad the unused lane of an odd-degree row
    localparam logic [DEF_DATA_W-1:0] PAD_MAG = '1;

endpackage

// File: rtl/cnu_min_seq_if.sv
// Stream bundle for cnu_min_seq.
//   in_*  : magnitude/index beats toward the min-finder (valid/ready)
//   out_* : {min2,min1} / {idx2,idx1} result toward the consumer (valid/ready)
// master = producer of beats / consumer of results; slave = the min-finder.
interface cnu_min_seq_if
    import cnu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IDX_W  = DEF_IDX_W
);

    logic                  in_valid;
    logic                  in_ready;
    logic [2*DATA_W-1:0]   in_data;
    logic [2*IDX_W-1:0]    in_idx;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   out_min;
    logic [2*IDX_W-1:0]    out_idx;

    modport master (
        output in_valid, in_data, in_idx, out_ready,
        input  in_ready, out_valid, out_min, out_idx
    );

    modport slave (
        input  in_valid, in_data, in_idx, out_ready,
        output in_ready, out_valid, out_min, out_idx
    );

endinterface

// File: rtl/cnu_pair_merge.sv
// Combinational min-2 datapath: sorts an incoming lane pair, then merges it
// with the running {min1,min2} pair. Indices travel with their magnitudes.
// Ports:
//   in_data_i/in_idx_i      two packed lanes (lane0 in the low half)
//   pad_lane1_i             replace lane1 by the all-ones / index-0 pad entry
//   run_min*_i/run_idx*_i   running pair, min1 <= min2
//   srt_*_o                 sorted incoming pair (for loading a new row)
//   mrg_*_o                 incoming pair merged into the running pair
module cnu_pair_merge
    import cnu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IDX_W  = DEF_IDX_W
) (
    input  logic [2*DATA_W-1:0] in_data_i,
    input  logic [2*IDX_W-1:0]  in_idx_i,
    input  logic                pad_lane1_i,
    input  logic [DATA_W-1:0]   run_min1_i,
    input  logic [DATA_W-1:0]   run_min2_i,
    input  logic [IDX_W-1:0]    run_idx1_i,
    input  logic [IDX_W-1:0]    run_idx2_i,
    output logic [DATA_W-1:0]   srt_min1_o,
    output logic [DATA_W-1:0]   srt_min2_o,
    output logic [IDX_W-1:0]    srt_idx1_o,
    output logic [IDX_W-1:0]    srt_idx2_o,
    output logic [DATA_W-1:0]   mrg_min1_o,
    output logic [DATA_W-1:0]   mrg_min2_o,
    output logic [IDX_W-1:0]    mrg_idx1_o,
    output logic [IDX_W-1:0]    mrg_idx2_o
);

    logic [DATA_W-1:0] mag0, mag1;
    logic [IDX_W-1:0]  idx0, idx1;

    // Lane unpack with optional odd-degree padding of lane1
    always_comb begin
        mag0 = in_data_i[DATA_W-1:0];
        idx0 = in_idx_i[IDX_W-1:0];
        mag1 = in_data_i[2*DATA_W-1:DATA_W];
        idx1 = in_idx_i[2*IDX_W-1:IDX_W];
        if (pad_lane1_i) begin
            mag1 = {DATA_W{1'b1}};
            idx1 = '0;
        end
    end

    // Pair sort: lane1 goes first only when strictly smaller
    always_comb begin
        srt_min1_o = mag0;
        srt_idx1_o = idx0;
        srt_min2_o = mag1;
        srt_idx2_o = idx1;
        if (mag1 < mag0) begin
            srt_min1_o = mag1;
            srt_idx1_o = idx1;
            srt_min2_o = mag0;
            srt_idx2_o = idx0;
        end
    end

    // Merge: strict compares keep the earlier (running) entry on ties
    always_comb begin
        mrg_min1_o = run_min1_i;
        mrg_idx1_o = run_idx1_i;
        mrg_min2_o = run_min2_i;
        mrg_idx2_o = run_idx2_i;
        if (srt_min1_o < run_min1_i) begin
            mrg_min1_o = srt_min1_o;
            mrg_idx1_o = srt_idx1_o;
            if (srt_min2_o < run_min1_i) begin
                mrg_min2_o = srt_min2_o;
                mrg_idx2_o = srt_idx2_o;
            end else begin
                mrg_min2_o = run_min1_i;
                mrg_idx2_o = run_idx1_i;
            end
        end else if (srt_min1_o < run_min2_i) begin
            mrg_min2_o = srt_min1_o;
            mrg_idx2_o = srt_idx1_o;
        end
    end

endmodule

// File: rtl/cnu_min_seq.sv
// Serial check-node min-finder controller. Consumes a row of magnitudes two
// per beat, keeps the running {min1,min2} with indices, and presents the
// registered result once the row degree has been consumed.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   cfg_deg    row degree, sampled on the first accepted beat of a row
//   bus        slave side of the beat/result stream bundle
//   busy       high while a row is being accumulated or its result is held
//   err_deg    sticky flag: a row started with an illegal degree
module cnu_min_seq
    import cnu_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned IDX_W   = DEF_IDX_W,
    parameter int unsigned MAX_DEG = DEF_MAX_DEG,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_deg,
    cnu_min_seq_if.slave     bus,
    output logic             busy,
    output logic             err_deg
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0] min1_q, min1_d, min2_q, min2_d;
    logic [IDX_W-1:0]  idx1_q, idx1_d, idx2_q, idx2_d;
    logic              busy_q, out_valid_q, err_q, err_d;

    logic              in_ready_c;
    logic              in_fire;
    logic              pad_lane1;
    logic              deg_bad;

    logic [DATA_W-1:0] srt_min1, srt_min2, mrg_min1, mrg_min2;
    logic [IDX_W-1:0]  srt_idx1, srt_idx2, mrg_idx1, mrg_idx2;

    // Ready is a pure decode of the state register, forced low while in reset
    assign in_ready_c = (state_q != ST_HOLD) && !rst;
    assign in_fire    = bus.in_valid && in_ready_c;
    // Last beat of an odd-degree row carries only one real entry
    assign pad_lane1  = (state_q == ST_ACCUM) && (remaining_q == CNT_W'(1));
    assign deg_bad    = (cfg_deg < CNT_W'(2)) || (cfg_deg > CNT_W'(MAX_DEG));

    cnu_pair_merge #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_merge (
        .in_data_i   (bus.in_data),
        .in_idx_i    (bus.in_idx),
        .pad_lane1_i (pad_lane1),
        .run_min1_i  (min1_q),
        .run_min2_i  (min2_q),
        .run_idx1_i  (idx1_q),
        .run_idx2_i  (idx2_q),
        .srt_min1_o  (srt_min1),
        .srt_min2_o  (srt_min2),
        .srt_idx1_o  (srt_idx1),
        .srt_idx2_o  (srt_idx2),
        .mrg_min1_o  (mrg_min1),
        .mrg_min2_o  (mrg_min2),
        .mrg_idx1_o  (mrg_idx1),
        .mrg_idx2_o  (mrg_idx2)
    );

    // Next-state, counter and running-pair update
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        min1_d      = min1_q;
        min2_d      = min2_q;
        idx1_d      = idx1_q;
        idx2_d      = idx2_q;
        err_d       = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    if (deg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        remaining_d = cfg_deg - CNT_W'(2);
                        min1_d      = srt_min1;
                        min2_d      = srt_min2;
                        idx1_d      = srt_idx1;
                        idx2_d      = srt_idx2;
                        state_d     = (cfg_deg == CNT_W'(2)) ? ST_HOLD : ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (in_fire) begin
                    min1_d      = mrg_min1;
                    min2_d      = mrg_min2;
                    idx1_d      = mrg_idx1;
                    idx2_d      = mrg_idx2;
                    remaining_d = remaining_q - (pad_lane1 ? CNT_W'(1) : CNT_W'(2));
                    if (remaining_d == '0) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            min1_q      <= '1;
            min2_q      <= '1;
            idx1_q      <= '0;
            idx2_q      <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            min1_q      <= min1_d;
            min2_q      <= min2_d;
            idx1_q      <= idx1_d;
            idx2_q      <= idx2_d;
            busy_q      <= (state_d != ST_IDLE);
            out_valid_q <= (state_d == ST_HOLD);
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_min   = {min2_q, min1_q};
    assign bus.out_idx   = {idx2_q, idx1_q};
    assign busy          = busy_q;
    assign err_deg       = err_q;

endmodule

// File: tb/tb_cnu_min_seq.sv
// Directed self-checking bench for cnu_min_seq.
module tb_cnu_min_seq;
    import cnu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] cfg_deg;
    logic       busy;
    logic       err_deg;

    int n_chk  = 0;
    int n_fail = 0;

    cnu_min_seq_if #(.DATA_W(8), .IDX_W(8)) bus ();

    cnu_min_seq #(
        .DATA_W  (8),
        .IDX_W   (8),
        .MAX_DEG (32),
        .CNT_W   (6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_deg (cfg_deg),
        .bus     (bus),
        .busy    (busy),
        .err_deg (err_deg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  deg;
        int          nb;
        logic [31:0] d0;   // lane0 magnitude of beat k in [8k +: 8]
        logic [31:0] d1;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [15:0] exp_min;  // {min2, min1}
        logic [15:0] exp_idx;  // {idx2, idx1}
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [5:0] deg, input int nb,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] i0, input logic [31:0] i1,
                                input logic [15:0] em, input logic [15:0] ei);
        vec_t v;
        v.deg = deg; v.nb = nb; v.d0 = d0; v.d1 = d1; v.i0 = i0; v.i1 = i1;
        v.exp_min = em; v.exp_idx = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Entered at a negedge; returns at the negedge after the beat is taken.
    task automatic send_beat(input string tag, input logic [5:0] deg,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] i0, input logic [7:0] i1);
        bit ok;
        ok = 1'b0;
        cfg_deg      = deg;
        bus.in_valid = 1'b1;
        bus.in_data  = {d1, d0};
        bus.in_idx   = {i1, i0};
        for (int k = 0; k < 20; k++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk({tag, "_accept"}, 32'(ok), 32'd1);
    endtask

    task automatic check_hold(input string tag, input logic [15:0] em, input logic [15:0] ei);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_out_min"},   32'(bus.out_min),   32'(em));
        chk({tag, "_out_idx"},   32'(bus.out_idx),   32'(ei));
        chk({tag, "_busy"},      32'(busy),          32'd1);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    endtask

    task automatic release_hold(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_rel_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rel_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_rel_busy"},      32'(busy),          32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // deg 6, even
        vecs[0] = mk(6'd6, 3, 32'h0008_0305, 32'h0002_0709, 32'h0004_0200, 32'h0005_0301,
                     16'h0302, 16'h0205);
        // deg 5, odd: lane1 of the last beat is padded away
        vecs[1] = mk(6'd5, 3, 32'h0001_060A, 32'h0063_0C04, 32'h0004_0200, 32'h0007_0301,
                     16'h0401, 16'h0104);
        // deg 4, ties keep the earlier index
        vecs[2] = mk(6'd4, 2, 32'h0000_0707, 32'h0000_0307, 32'h0000_0200, 32'h0000_0301,
                     16'h0703, 16'h0003);
        // deg 3, equal values plus padded lane
        vecs[3] = mk(6'd3, 2, 32'h0000_0505, 32'h0000_AA05, 32'h0000_0A08, 32'h0000_0B09,
                     16'h0505, 16'h0908);
        // deg 2, all-ones magnitudes
        vecs[4] = mk(6'd2, 1, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0003, 32'h0000_0004,
                     16'hFFFF, 16'h0403);
        // deg 7, four beats, last one padded
        vecs[5] = mk(6'd7, 4, 32'h0C28_1914, 32'h320A_0F1E, 32'h0604_0200, 32'h0705_0301,
                     16'h0C0A, 16'h0605);

        rst           = 1'b1;
        cfg_deg       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_idx    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_err_deg",   32'(err_deg),       32'd0);
        chk("rst_out_min",   32'(bus.out_min),   32'({PAD_MAG, PAD_MAG}));
        chk("rst_out_idx",   32'(bus.out_idx),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Table-driven rows
        for (int v = 0; v < NV; v++) begin
            for (int b = 0; b < vecs[v].nb; b++) begin
                send_beat($sformatf("v%0d_b%0d", v, b), vecs[v].deg,
                          vecs[v].d0[b*8 +: 8], vecs[v].d1[b*8 +: 8],
                          vecs[v].i0[b*8 +: 8], vecs[v].i1[b*8 +: 8]);
                if (b < vecs[v].nb - 1)
                    chk($sformatf("v%0d_b%0d_early_valid", v, b), 32'(bus.out_valid), 32'd0);
            end
            bus.in_valid = 1'b0;
            check_hold($sformatf("v%0d", v), vecs[v].exp_min, vecs[v].exp_idx);
            release_hold($sformatf("v%0d", v));
        end

        // Maximum degree: 16 beats of (50,60) except beat 9 = (8,7)
        for (int b = 0; b < 16; b++) begin
            if (b == 9)
                send_beat($sformatf("max_b%0d", b), 6'd32, 8'd8, 8'd7, 8'(2*b), 8'(2*b+1));
            else
                send_beat($sformatf("max_b%0d", b), 6'd32, 8'd50, 8'd60, 8'(2*b), 8'(2*b+1));
            if (b < 15)
                chk($sformatf("max_b%0d_early_valid", b), 32'(bus.out_valid), 32'd0);
        end
        bus.in_valid = 1'b0;
        check_hold("max", 16'h0807, 16'h1213);
        release_hold("max");

        // Backpressure with a pending beat that must be ignored during HOLD
        send_beat("bp", 6'd2, 8'd4, 8'd6, 8'd1, 8'd2);
        bus.in_data = {8'd0, 8'd0};
        bus.in_idx  = {8'd9, 8'd9};
        for (int c = 0; c < 3; c++) begin
            check_hold($sformatf("bp_c%0d", c), 16'h0604, 16'h0201);
            @(negedge clk);
        end
        check_hold("bp_c3", 16'h0604, 16'h0201);
        bus.in_valid = 1'b0;
        release_hold("bp");

        // Reset in the middle of a row
        send_beat("mr_b0", 6'd8, 8'd2, 8'd3, 8'd10, 8'd11);
        send_beat("mr_b1", 6'd8, 8'd1, 8'd4, 8'd12, 8'd13);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mr_rst_in_ready",  32'(bus.in_ready),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_busy",      32'(busy),          32'd0);
        chk("mr_out_min",   32'(bus.out_min),   32'hFFFF);
        send_beat("mr_new", 6'd2, 8'd9, 8'd1, 8'd5, 8'd6);
        bus.in_valid = 1'b0;
        check_hold("mr_new", 16'h0901, 16'h0506);
        release_hold("mr_new");

        // Illegal degrees: beat dropped, sticky error, no result
        begin
            logic [5:0] bad [3];
            bad[0] = 6'd1; bad[1] = 6'd40; bad[2] = 6'd33;
            for (int k = 0; k < 3; k++) begin
                send_beat($sformatf("bad%0d", k), bad[k], 8'd0, 8'd0, 8'd1, 8'd2);
                bus.in_valid = 1'b0;
                chk($sformatf("bad%0d_err", k),       32'(err_deg),       32'd1);
                chk($sformatf("bad%0d_busy", k),      32'(busy),          32'd0);
                chk($sformatf("bad%0d_in_ready", k),  32'(bus.in_ready),  32'd1);
                repeat (2) @(negedge clk);
                chk($sformatf("bad%0d_out_valid", k), 32'(bus.out_valid), 32'd0);
                chk($sformatf("bad%0d_out_min", k),   32'(bus.out_min),   32'h0901);
            end
        end

        // A legal row still works and the error stays set
        send_beat("post_err", 6'd2, 8'd20, 8'd10, 8'd7, 8'd8);
        bus.in_valid = 1'b0;
        check_hold("post_err", 16'h140A, 16'h0708);
        chk("post_err_sticky", 32'(err_deg), 32'd1);
        release_hold("post_err");

        // Reset clears the sticky error
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("err_cleared", 32'(err_deg), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cnu_min_seq.md
Name: cnu_min_seq

Overview:
- Serial check-node min-finder controller for the LDPC check node unit (CNU).
- Accepts a row's variable-to-check magnitudes two per beat over a valid/ready stream.
- Sequences a 4-input min-2 merge datapath to keep a running {min1, min2} with their indices.
- When the configured row degree has been consumed, presents the registered result on an output handshake.

Parameters:
- DATA_W, 8, magnitude width.
- IDX_W, 8, index width.
- MAX_DEG, 32, largest legal row degree.
- CNT_W, 6, width of the degree counter; must satisfy 2^CNT_W > MAX_DEG.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_deg  in  CNT_W  row degree; sampled only on the first accepted beat of a row.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
- in_data  in  2*DATA_W  lane0 = [DATA_W-1:0], lane1 = upper half.
- in_idx  in  2*IDX_W  index of each lane, same packing as in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid and out_ready are both high.
- out_min  out  2*DATA_W  {min2, min1}.
- out_idx  out  2*IDX_W  {idx2, idx1}.
- busy  out  1  high in ACCUM or HOLD.
- err_deg  out  1  sticky illegal-degree flag.

Behaviour:
- Reset: state=IDLE; in_ready=0 during the reset cycle; out_valid=0; out_min=all ones; out_idx=0; busy=0; err_deg=0; remaining=0. Reset mid-row or mid-HOLD discards all partial state. No output appears for the aborted row.
- States:
  - IDLE: in_ready=1.
  - ACCUM: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- IDLE, accepted beat:
  - If cfg_deg<2 or cfg_deg>MAX_DEG: beat is dropped, err_deg is set (sticky until rst), stay IDLE.
  - Otherwise: latch remaining=cfg_deg-2, load the running pair with the sorted incoming pair. Go to ACCUM, or to HOLD if remaining==0.
- ACCUM, accepted beat:
  - If remaining==1, lane1 is masked to value all ones, index 0 (odd-degree padding).
  - Merge the sorted incoming pair with the running pair.
  - Decrement remaining by 2, or by 1 when masked.
  - When remaining reaches 0, go to HOLD.
- Pair sort rule: lane0 is ordered first unless lane1 < lane0 (strict). On ties the lower lane wins.
- Merge rule: running (r1<=r2) with incoming (a<=b). Comparisons are strict, so on equal values the running (earlier) entry wins.
  - new min1 = a<r1 ? a : r1.
  - If a<r1: new min2 = b<r1 ? b : r1.
  - Else: new min2 = a<r2 ? a : r2.
  - Indices travel with their values.
- Result timing: out_min/out_idx are registered and valid the cycle after the final beat is accepted. Latency from last beat to out_valid = 1 cycle. Throughput = one beat per cycle within a row.
- HOLD:
  - Outputs stay stable while out_ready=0.
  - On the out_valid and out_ready handshake, return to IDLE. in_ready rises the following cycle.
  - There is no overlap of the next row with HOLD.
- Unsigned compares, no arithmetic beyond the counter. The counter never wraps; remaining only decrements from a legal value.
- in_valid during HOLD is ignored; the upstream holds the beat.

Decomposition:
- Shared package cnu_pkg holds:
  - DATA_W/IDX_W defaults;
  - the state enum (IDLE, ACCUM, HOLD);
  - the pad constant (all-ones magnitude).
- One combinational sub-module, cnu_pair_merge: sort incoming pair, then merge with the running pair. It is the only datapath.
- FSM, counter and handshake live in cnu_min_seq.

Test Plan:
- Even degree: deg=6; beats data (5,9),(3,7),(8,2), idx (0,1),(2,3),(4,5) -> one cycle after the third beat, out_min={3,2}, out_idx={2,5}.
- Odd degree: deg=5; beats (10,4),(6,12),(1,99 ignored), idx (0,1),(2,3),(4,7) -> out_min={4,1}, out_idx={1,4}; lane1 of the last beat never appears in the result.
- Tie handling: deg=4; beats (7,7),(7,3), idx (0,1),(2,3) -> out_min={7,3}, out_idx={0,3}; the earlier index wins the tie.
- Backpressure: deg=2, beat (4,6); hold out_ready=0 for 3 cycles -> out_valid and outputs stable, in_ready=0 throughout. Handshake on cycle 4 -> IDLE, in_ready=1 on the next cycle.
- Reset mid-row: deg=8, two beats accepted, assert rst for one cycle -> out_valid=0, busy=0. A new deg=2 row with (9,1) then yields out_min={9,1} with no residue from the aborted row.
- Illegal degree: cfg_deg=1 or 40 on the first beat -> beat dropped, err_deg=1 (sticky), state stays IDLE, out_valid never asserts.
